// File: rtl/hfg_feature_engine.sv
`default_nettype none
// ============================================================================
// hfg_feature_engine : Haar feature generator for one detection window
// Rev 1.0
// ============================================================================
module hfg_feature_engine #(
  parameter int II_W       = 21,
  parameter int NREC       = 8,
  parameter int NFEAT      = 100,
  parameter int FADDR_W    = 7,
  parameter int FEAT_W     = 32,
  parameter int NORM_MODE  = 1,
  parameter int NORM_SHIFT = 9
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iRun,
  input  logic [15:0]              iNorm,
  output logic [FADDR_W-1:0]       oAddr_IIBG,
  output logic                     oRdreq_IIBG,
  input  logic                     iReady,
  input  logic [NREC*4*II_W-1:0]   i4Rec,
  input  logic [NREC-1:0]          iSign,
  input  logic [NREC-1:0]          iRecEn,
  output logic                     oBusy,
  output logic                     oWrreq_FBR,
  output logic [FADDR_W-1:0]       oAddr_FBR,
  output logic signed [FEAT_W-1:0] oFeature,
  output logic                     oSat,
  output logic                     oFinish,
  output logic                     oFull_FBR
);

  localparam int RW = II_W + 2;
  localparam int TW = II_W + 2 + $clog2(NREC);
  localparam int NW = TW + 17;
  localparam int CW = FADDR_W + 1;
  localparam logic [CW-1:0]      NFEAT_C = CW'(NFEAT);
  localparam logic [FADDR_W-1:0] LAST_C  = FADDR_W'(NFEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [FADDR_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CW-1:0]        rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [15:0]          norm_q, norm_d;
  logic                 full_q, full_d;

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [FADDR_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [NREC-1:0]      sign1_q, sign1_d;
  logic signed [RW-1:0] rsum_q [NREC];
  logic signed [RW-1:0] rsum_d [NREC];
  logic signed [TW-1:0] total_q, total_d;
  logic signed [FEAT_W-1:0] feat_q, feat_d;
  logic                 sat_q, sat_d;

  logic                 accept_w;
  logic signed [NW-1:0] prod_w;
  logic signed [NW-1:0] norm_w;

  // Responses are only tagged while a window is open and slots remain.
  assign accept_w = iReady && (state_q != S_IDLE) && (rsp_cnt_q < NFEAT_C);

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q + CW'(accept_w);
    wr_cnt_d  = wr_cnt_q + CW'(v3_q);
    norm_d    = norm_q;
    full_d    = full_q;
    case (state_q)
      S_IDLE: begin
        if (iRun) begin
          norm_d    = iNorm;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          wr_cnt_d  = '0;
          full_d    = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        req_cnt_d = req_cnt_q + FADDR_W'(1);
        if (req_cnt_q == LAST_C) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // wr_cnt_d already includes a write landing this cycle.
        if (wr_cnt_d == NFEAT_C) begin
          state_d = S_DONE;
          full_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oBusy       = (state_q != S_IDLE);
  assign oRdreq_IIBG = (state_q == S_FETCH);
  assign oAddr_IIBG  = req_cnt_q;
  assign oFinish     = (state_q == S_DONE);
  assign oFull_FBR   = full_q;

  for (genvar r = 0; r < NREC; r++) begin : g_rect
    logic [II_W-1:0] a_w, b_w, c_w, d_w;
    assign a_w = i4Rec[r*4*II_W          +: II_W];
    assign b_w = i4Rec[r*4*II_W + II_W   +: II_W];
    assign c_w = i4Rec[r*4*II_W + 2*II_W +: II_W];
    assign d_w = i4Rec[r*4*II_W + 3*II_W +: II_W];
    assign rsum_d[r] = iRecEn[r]
        ? ($signed({2'b00, d_w}) - $signed({2'b00, b_w})
           - $signed({2'b00, c_w}) + $signed({2'b00, a_w}))
        : '0;
  end

  always_comb begin
    v1_d    = accept_w;
    tag1_d  = rsp_cnt_q[FADDR_W-1:0];
    sign1_d = iSign;
    v2_d    = v1_q;
    tag2_d  = tag1_q;
    v3_d    = v2_q;
    tag3_d  = tag2_q;
    total_d = '0;
    for (int r = 0; r < NREC; r++) begin
      total_d = sign1_q[r] ? (total_d - TW'(rsum_q[r])) : (total_d + TW'(rsum_q[r]));
    end
  end

  // Full-width signed product keeps mode 2 exact before the floor shift.
  assign prod_w = $signed(NW'(total_q)) * $signed({{(NW-16){1'b0}}, norm_q});

  always_comb begin
    case (NORM_MODE)
      1:       norm_w = NW'(total_q >>> NORM_SHIFT);
      2:       norm_w = prod_w >>> 16;
      default: norm_w = NW'(total_q);
    endcase
  end

  if (NW > FEAT_W) begin : g_sat
    logic [NW-FEAT_W:0] top_w;
    assign top_w = norm_w[NW-1:FEAT_W-1];
    always_comb begin
      sat_d  = !((&top_w) || (~|top_w));
      feat_d = norm_w[FEAT_W-1:0];
      if (sat_d) feat_d = norm_w[NW-1] ? {1'b1, {(FEAT_W-1){1'b0}}}
                                       : {1'b0, {(FEAT_W-1){1'b1}}};
    end
  end else begin : g_nosat
    assign sat_d  = 1'b0;
    assign feat_d = FEAT_W'(norm_w);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      wr_cnt_q  <= '0;
      norm_q    <= '0;
      full_q    <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      tag1_q    <= '0;
      tag2_q    <= '0;
      tag3_q    <= '0;
      sign1_q   <= '0;
      total_q   <= '0;
      feat_q    <= '0;
      sat_q     <= 1'b0;
      for (int r = 0; r < NREC; r++) rsum_q[r] <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      norm_q    <= norm_d;
      full_q    <= full_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      tag3_q    <= tag3_d;
      sign1_q   <= sign1_d;
      total_q   <= total_d;
      feat_q    <= feat_d;
      sat_q     <= sat_d;
      for (int r = 0; r < NREC; r++) rsum_q[r] <= rsum_d[r];
    end
  end

  assign oWrreq_FBR = v3_q;
  assign oAddr_FBR  = tag3_q;
  assign oFeature   = feat_q;
  assign oSat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_hfg_feature_engine.sv
`default_nettype none
// ============================================================================
// tb_hfg_feature_engine : directed bench, three normalisation modes in parallel
// Rev 1.0
// ============================================================================
module tb_hfg_feature_engine;

  localparam int II_W    = 21;
  localparam int NREC    = 2;
  localparam int NFEAT   = 100;
  localparam int FADDR_W = 7;
  localparam int FEAT_W  = 8;
  localparam int PW      = NREC * 4 * II_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, run_i, ready_i;
  logic [15:0]        norm_i;
  logic [PW-1:0]      rec_i;
  logic [NREC-1:0]    sign_i, en_i;

  logic [FADDR_W-1:0] m0_ai, m1_ai, m2_ai, m0_af, m1_af, m2_af;
  logic               m0_rd, m1_rd, m2_rd, m0_busy, m1_busy, m2_busy;
  logic               m0_wr, m1_wr, m2_wr, m0_sat, m1_sat, m2_sat;
  logic               m0_fin, m1_fin, m2_fin, m0_full, m1_full, m2_full;
  logic signed [FEAT_W-1:0] m0_f, m1_f, m2_f;

  hfg_feature_engine #(.II_W(II_W), .NREC(NREC), .NFEAT(NFEAT), .FADDR_W(FADDR_W),
                       .FEAT_W(FEAT_W), .NORM_MODE(0), .NORM_SHIFT(9)) u_m0 (
    .iClk(clk), .iReset(rst_i), .iRun(run_i), .iNorm(norm_i),
    .oAddr_IIBG(m0_ai), .oRdreq_IIBG(m0_rd), .iReady(ready_i), .i4Rec(rec_i),
    .iSign(sign_i), .iRecEn(en_i), .oBusy(m0_busy), .oWrreq_FBR(m0_wr),
    .oAddr_FBR(m0_af), .oFeature(m0_f), .oSat(m0_sat), .oFinish(m0_fin),
    .oFull_FBR(m0_full));

  hfg_feature_engine #(.II_W(II_W), .NREC(NREC), .NFEAT(NFEAT), .FADDR_W(FADDR_W),
                       .FEAT_W(FEAT_W), .NORM_MODE(1), .NORM_SHIFT(9)) u_m1 (
    .iClk(clk), .iReset(rst_i), .iRun(run_i), .iNorm(norm_i),
    .oAddr_IIBG(m1_ai), .oRdreq_IIBG(m1_rd), .iReady(ready_i), .i4Rec(rec_i),
    .iSign(sign_i), .iRecEn(en_i), .oBusy(m1_busy), .oWrreq_FBR(m1_wr),
    .oAddr_FBR(m1_af), .oFeature(m1_f), .oSat(m1_sat), .oFinish(m1_fin),
    .oFull_FBR(m1_full));

  hfg_feature_engine #(.II_W(II_W), .NREC(NREC), .NFEAT(NFEAT), .FADDR_W(FADDR_W),
                       .FEAT_W(FEAT_W), .NORM_MODE(2), .NORM_SHIFT(9)) u_m2 (
    .iClk(clk), .iReset(rst_i), .iRun(run_i), .iNorm(norm_i),
    .oAddr_IIBG(m2_ai), .oRdreq_IIBG(m2_rd), .iReady(ready_i), .i4Rec(rec_i),
    .iSign(sign_i), .iRecEn(en_i), .oBusy(m2_busy), .oWrreq_FBR(m2_wr),
    .oAddr_FBR(m2_af), .oFeature(m2_f), .oSat(m2_sat), .oFinish(m2_fin),
    .oFull_FBR(m2_full));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write/request log of the mode-0 instance, sampled on the falling edge.
  int cyc = 0, n_wr = 0, n_rd = 0, n_fin = 0, rd_err = 0;
  int last_wr_cyc = 0, fin_cyc = 0;
  int log_addr [256];
  int log_feat [256];

  always @(negedge clk) begin
    if (m0_wr) begin
      if (n_wr < 256) begin
        log_addr[n_wr] = int'(m0_af);
        log_feat[n_wr] = int'(m0_f);
      end
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (m0_fin) begin
      n_fin++;
      fin_cyc = cyc;
    end
    if (m0_rd) begin
      if (int'(m0_ai) != n_rd) rd_err++;
      n_rd++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_wr = 0; n_rd = 0; n_fin = 0; rd_err = 0;
  endtask

  function automatic logic [PW-1:0] pack(input int a0, b0, c0, d0, a1, b1, c1, d1);
    logic [PW-1:0] v;
    v = '0;
    v[0*II_W +: II_W] = II_W'(a0);
    v[1*II_W +: II_W] = II_W'(b0);
    v[2*II_W +: II_W] = II_W'(c0);
    v[3*II_W +: II_W] = II_W'(d0);
    v[4*II_W +: II_W] = II_W'(a1);
    v[5*II_W +: II_W] = II_W'(b1);
    v[6*II_W +: II_W] = II_W'(c1);
    v[7*II_W +: II_W] = II_W'(d1);
    return v;
  endfunction

  // One response, then the write is checked exactly three cycles later.
  task automatic resp(input string tag, input logic [PW-1:0] rec, input logic [1:0] sg,
                      input logic [1:0] en, input int idx, input int e0, input int s0,
                      input int e1, input int e2, input int s2);
    ready_i = 1'b1; rec_i = rec; sign_i = sg; en_i = en;
    tick();
    ready_i = 1'b0; run_i = 1'b0;
    tick();
    tick();
    check({tag, "_wr"},   longint'(m0_wr), 1);
    check({tag, "_addr"}, longint'(m0_af), idx);
    check({tag, "_m0"},   longint'(m0_f), e0);
    check({tag, "_sat0"}, longint'(m0_sat), s0);
    check({tag, "_m1"},   longint'(m1_f), e1);
    check({tag, "_m2"},   longint'(m2_f), e2);
    check({tag, "_sat2"}, longint'(m2_sat), s2);
  endtask

  // Drives iReady two cycles after each request; rect0 D carries the response index.
  task automatic loopback(input int stop_writes, input int budget);
    logic d1, d2;
    int   idx;
    d1 = 1'b0; d2 = 1'b0; idx = 0;
    for (int k = 0; k < budget && n_fin == 0 && n_wr < stop_writes; k++) begin
      ready_i = d2;
      if (d2) begin
        rec_i = pack(0, 0, 0, idx, 0, 0, 0, 0);
        sign_i = 2'b00; en_i = 2'b01;
        idx++;
      end
      d2 = d1;
      d1 = m0_rd;
      tick();
    end
    ready_i = 1'b0;
  endtask

  initial begin
    int bad;
    int n0;
    rst_i = 1'b1; run_i = 1'b0; ready_i = 1'b0; norm_i = '0;
    rec_i = '0; sign_i = '0; en_i = '0;
    repeat (3) tick();
    check("rst_busy",  longint'(m0_busy), 0);
    check("rst_rdreq", longint'(m0_rd), 0);
    check("rst_wrreq", longint'(m0_wr), 0);
    check("rst_full",  longint'(m0_full), 0);
    check("rst_fin",   longint'(m0_fin), 0);
    rst_i = 1'b0;
    tick();

    // iReady while idle must not produce writes
    clear_log();
    ready_i = 1'b1; rec_i = pack(0, 0, 0, 50, 0, 0, 0, 0); en_i = 2'b11;
    repeat (3) tick();
    ready_i = 1'b0;
    repeat (4) tick();
    check("idle_ready_writes", n_wr, 0);
    check("idle_busy", longint'(m0_busy), 0);

    // Window 1: directed features
    clear_log();
    norm_i = 16'h8000; run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check("w1_busy",  longint'(m0_busy), 1);
    check("w1_rdreq", longint'(m0_rd), 1);
    check("w1_addr0", longint'(m0_ai), 0);

    resp("f0", pack(0, 10, 20, 50, 5, 5, 5, 30), 2'b10, 2'b11, 0, -5,   0, -1,  -3,   0);
    resp("f1", pack(0, 0, 0, 300, 0, 0, 0, 0),   2'b00, 2'b01, 1, 127,  1,  0,  127,  1);
    resp("f2", pack(0, 0, 0, 300, 0, 0, 0, 0),   2'b01, 2'b01, 2, -128, 1, -1,  -128, 1);
    resp("f3", pack(0, 0, 0, 1000, 0, 0, 0, 0),  2'b01, 2'b01, 3, -128, 1, -2,  -128, 1);
    resp("f4", pack(0, 0, 0, 7, 0, 0, 0, 0),     2'b00, 2'b01, 4, 7,    0,  0,  3,    0);
    run_i = 1'b1;
    resp("f5", pack(1, 2, 3, 900, 4, 5, 6, 700), 2'b00, 2'b00, 5, 0,   0,  0,  0,    0);
    check("w1_run_ignored_busy", longint'(m0_busy), 1);
    check("w1_run_ignored_full", longint'(m0_full), 0);

    // Remaining 94 responses plus two surplus ones that must be ignored
    rec_i = '0; sign_i = '0; en_i = 2'b11;
    for (int i = 0; i < 96; i++) begin
      ready_i = 1'b1;
      tick();
    end
    ready_i = 1'b0;
    for (int k = 0; k < 300 && n_fin == 0; k++) tick();
    check("w1_finish_seen", n_fin, 1);
    repeat (3) tick();
    check("w1_writes", n_wr, NFEAT);
    check("w1_fin_pulses", n_fin, 1);
    check("w1_fin_after_last", fin_cyc - last_wr_cyc, 1);
    check("w1_reqs", n_rd, NFEAT);
    check("w1_req_order", rd_err, 0);
    bad = 0;
    for (int i = 0; i < NFEAT && i < n_wr; i++) if (log_addr[i] != i) bad++;
    check("w1_wr_order", bad, 0);
    check("w1_log_f0", log_feat[0], -5);
    check("w1_log_f99", log_feat[99], 0);
    check("w1_full", longint'(m0_full), 1);
    check("w1_idle", longint'(m0_busy), 0);

    ready_i = 1'b1;
    repeat (2) tick();
    ready_i = 1'b0;
    repeat (5) tick();
    check("post_done_ready_writes", n_wr, NFEAT);
    check("full_held", longint'(m0_full), 1);

    // Window 2: iReady two cycles after each request
    clear_log();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check("w2_full_cleared", longint'(m0_full), 0);
    loopback(1000, 600);
    check("w2_finish_seen", n_fin, 1);
    repeat (3) tick();
    check("w2_writes", n_wr, NFEAT);
    check("w2_fin_pulses", n_fin, 1);
    check("w2_fin_after_last", fin_cyc - last_wr_cyc, 1);
    bad = 0;
    for (int i = 0; i < NFEAT && i < n_wr; i++) if (log_addr[i] != i || log_feat[i] != i) bad++;
    check("w2_addr_feat", bad, 0);
    check("w2_full", longint'(m0_full), 1);

    // Window 3: reset at feature 40
    clear_log();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    loopback(40, 400);
    check("w3_reached_40", n_wr, 40);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_busy",  longint'(m0_busy), 0);
    check("mid_rst_rdreq", longint'(m0_rd), 0);
    check("mid_rst_wrreq", longint'(m0_wr), 0);
    check("mid_rst_feat",  longint'(m0_f), 0);
    check("mid_rst_addr",  longint'(m0_ai), 0);
    n0 = n_wr;
    for (int i = 0; i < 10; i++) begin
      ready_i = (i % 3 == 0);
      tick();
    end
    ready_i = 1'b0;
    check("mid_rst_no_writes", n_wr, n0);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check("restart_rdreq", longint'(m0_rd), 1);
    check("restart_addr0", longint'(m0_ai), 0);
    tick();
    check("restart_addr1", longint'(m0_ai), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
